// File: rtl/credit_counter_multi.sv
// Per-channel credit pools with multi-credit give/take per cycle; count updates 1 cycle after the edge.
// take_ready_o is combinational from the registered count and current take_amt_i; gives are not bypassed.
// Overflow saturates at NumCredits and latches a sticky per-channel error until init or reset.
module credit_counter_multi #(
    parameter int NumChannels     = 4,
    parameter int NumCredits      = 8,
    parameter int MaxStep         = 2,
    parameter bit InitCreditEmpty = 1'b0,
    parameter int LowWater        = 1,
    localparam int CntW           = $clog2(NumCredits + 1),
    localparam int StepW          = $clog2(MaxStep + 1),
    localparam int InitNumCredits = InitCreditEmpty ? 0 : NumCredits
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumChannels*StepW-1:0] give_amt_i,
    input  logic [NumChannels-1:0]       take_valid_i,
    input  logic [NumChannels*StepW-1:0] take_amt_i,
    output logic [NumChannels-1:0]       take_ready_o,
    input  logic [NumChannels-1:0]       init_i,
    output logic [NumChannels*CntW-1:0]  credit_o,
    output logic [NumChannels-1:0]       left_o,
    output logic [NumChannels-1:0]       low_o,
    output logic [NumChannels-1:0]       full_o,
    output logic [NumChannels-1:0]       err_o
);

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic [CntW-1:0]  credit_q;
        logic             err_q;
        logic [StepW-1:0] give_amt;
        logic [StepW-1:0] take_amt;
        logic             take_fire;
        logic             step_err;
        logic [CntW:0]    sum;

        assign give_amt = give_amt_i[c*StepW +: StepW];
        assign take_amt = take_amt_i[c*StepW +: StepW];

        assign take_ready_o[c] = !rst_i && !init_i[c] &&
                                 ({1'b0, credit_q} >= (CntW+1)'(take_amt));
        assign take_fire = take_valid_i[c] & take_ready_o[c];

        // CntW+1 bits is enough: both operands fit CntW bits and the grant rules out underflow.
        assign sum = {1'b0, credit_q} + (CntW+1)'(give_amt)
                   - (take_fire ? (CntW+1)'(take_amt) : '0);

        assign step_err = (give_amt > StepW'(MaxStep)) ||
                          (take_valid_i[c] && (take_amt > StepW'(MaxStep)));

        always_ff @(posedge clk_i) begin
            if (rst_i || init_i[c]) begin
                credit_q <= CntW'(InitNumCredits);
                err_q    <= 1'b0;
            end else begin
                if (sum > (CntW+1)'(NumCredits)) begin
                    credit_q <= CntW'(NumCredits);
                    err_q    <= 1'b1;
                end else begin
                    credit_q <= sum[CntW-1:0];
                    if (step_err) begin
                        err_q <= 1'b1;
                    end
                end
            end
        end

        assign credit_o[c*CntW +: CntW] = credit_q;
        assign left_o[c] = (credit_q != '0);
        assign low_o[c]  = (credit_q < CntW'(LowWater));
        assign full_o[c] = (credit_q == CntW'(NumCredits));
        assign err_o[c]  = err_q;
    end

endmodule

// File: tb/tb_credit_counter_multi.sv
// Bench for credit_counter_multi: one full-start and one empty-start instance sharing stimulus.
module tb_credit_counter_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  give_amt;
    logic [3:0]  take_valid;
    logic [7:0]  take_amt;
    logic [3:0]  init;
    logic [3:0]  rdy0, left0, low0, full0, err0;
    logic [3:0]  rdy1, left1, low1, full1, err1;
    logic [15:0] cr0, cr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    credit_counter_multi #(.InitCreditEmpty(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .give_amt_i(give_amt), .take_valid_i(take_valid),
        .take_amt_i(take_amt), .take_ready_o(rdy0), .init_i(init), .credit_o(cr0),
        .left_o(left0), .low_o(low0), .full_o(full0), .err_o(err0));

    credit_counter_multi #(.InitCreditEmpty(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .give_amt_i(give_amt), .take_valid_i(take_valid),
        .take_amt_i(take_amt), .take_ready_o(rdy1), .init_i(init), .credit_o(cr1),
        .left_o(left1), .low_o(low1), .full_o(full1), .err_o(err1));

    // Reference pools: plain integer counts per instance and channel.
    int mcnt [2][4];
    bit merr [2][4];
    int init_val [2] = '{8, 0};

    typedef struct packed {
        logic        rst;
        logic [3:0]  init;
        logic [3:0]  valid;
        logic [7:0]  give;
        logic [7:0]  amt;
        logic [3:0]  exp_rdy;
        logic [15:0] exp_cr;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t tbl [27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_rdy(input int d);
        logic [3:0] r;
        for (int c = 0; c < 4; c++)
            r[c] = !rst && !init[c] && (mcnt[d][c] >= int'(take_amt[c*2 +: 2]));
        return r;
    endfunction

    function automatic logic [11:0] exp_flags(input logic [15:0] cr);
        logic [3:0] l, lo, f;
        for (int c = 0; c < 4; c++) begin
            l[c]  = (cr[c*4 +: 4] != 0);
            lo[c] = (cr[c*4 +: 4] < 1);
            f[c]  = (cr[c*4 +: 4] == 8);
        end
        return {l, lo, f};
    endfunction

    task automatic model_update();
        logic [3:0] r [2];
        r[0] = model_rdy(0);
        r[1] = model_rdy(1);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                int g, t, s;
                g = int'(give_amt[c*2 +: 2]);
                t = int'(take_amt[c*2 +: 2]);
                if (rst || init[c]) begin
                    mcnt[d][c] = init_val[d];
                    merr[d][c] = 1'b0;
                end else begin
                    s = mcnt[d][c] + g - ((take_valid[c] && r[d][c]) ? t : 0);
                    if (s > 8) begin
                        mcnt[d][c] = 8;
                        merr[d][c] = 1'b1;
                    end else begin
                        mcnt[d][c] = s;
                    end
                    if (g > 2 || (take_valid[c] && t > 2)) merr[d][c] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model(input int d, input logic [15:0] cr, input logic [3:0] lf,
                               input logic [3:0] lo, input logic [3:0] fu, input logic [3:0] er);
        logic [15:0] ecr;
        logic [3:0]  eer;
        for (int c = 0; c < 4; c++) begin
            ecr[c*4 +: 4] = 4'(mcnt[d][c]);
            eer[c] = merr[d][c];
        end
        chk($sformatf("model_credit_dut%0d", d), 32'(cr), 32'(ecr));
        chk($sformatf("model_flags_dut%0d", d), 32'({lf, lo, fu}), 32'(exp_flags(ecr)));
        chk($sformatf("model_err_dut%0d", d), 32'(er), 32'(eer));
    endtask

    task automatic pre_edge();
        @(negedge clk);
        chk("model_rdy_dut0", 32'(rdy0), 32'(model_rdy(0)));
        chk("model_rdy_dut1", 32'(rdy1), 32'(model_rdy(1)));
    endtask

    task automatic post_edge();
        @(posedge clk);
        model_update();
        #1;
        check_model(0, cr0, left0, low0, full0, err0);
        check_model(1, cr1, left1, low1, full1, err1);
    endtask

    task automatic drive(input logic r, input logic [3:0] in, input logic [3:0] v,
                         input logic [7:0] g, input logic [7:0] a);
        rst = r; init = in; take_valid = v; give_amt = g; take_amt = a;
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                mcnt[d][c] = 0;
                merr[d][c] = 1'b0;
            end

        // Directed sequence; channel 0 sits at the low end of every packed field.
        tbl[0]  = '{1'b0, 4'h0, 4'h0, 8'h00, 8'hAA, 4'hF, 16'h8888, 4'h0};
        tbl[1]  = '{1'b0, 4'h0, 4'h1, 8'h00, 8'hAA, 4'hF, 16'h8886, 4'h0};
        tbl[2]  = '{1'b0, 4'h0, 4'h1, 8'h00, 8'hAA, 4'hF, 16'h8884, 4'h0};
        tbl[3]  = '{1'b0, 4'h0, 4'h1, 8'h00, 8'hAA, 4'hF, 16'h8882, 4'h0};
        tbl[4]  = '{1'b0, 4'h0, 4'h1, 8'h00, 8'hAA, 4'hF, 16'h8880, 4'h0};
        tbl[5]  = '{1'b0, 4'h0, 4'h1, 8'h00, 8'hAA, 4'hE, 16'h8880, 4'h0};
        tbl[6]  = '{1'b0, 4'h0, 4'h2, 8'h00, 8'hAA, 4'hE, 16'h8860, 4'h0};
        tbl[7]  = '{1'b0, 4'h0, 4'h2, 8'h00, 8'hAA, 4'hE, 16'h8840, 4'h0};
        tbl[8]  = '{1'b0, 4'h0, 4'h2, 8'h00, 8'hA6, 4'hE, 16'h8830, 4'h0};
        tbl[9]  = '{1'b0, 4'h0, 4'h2, 8'h04, 8'hAA, 4'hE, 16'h8820, 4'h0};
        tbl[10] = '{1'b0, 4'h0, 4'h2, 8'h00, 8'hA6, 4'hE, 16'h8810, 4'h0};
        tbl[11] = '{1'b0, 4'h0, 4'h2, 8'h08, 8'hAA, 4'hC, 16'h8830, 4'h0};
        tbl[12] = '{1'b0, 4'h0, 4'h0, 8'h10, 8'hAA, 4'hE, 16'h8830, 4'h4};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 8'h00, 8'hAA, 4'hE, 16'h8830, 4'h4};
        tbl[14] = '{1'b0, 4'h0, 4'h0, 8'h00, 8'hAA, 4'hE, 16'h8830, 4'h4};
        tbl[15] = '{1'b0, 4'h0, 4'h0, 8'h00, 8'hAA, 4'hE, 16'h8830, 4'h4};
        tbl[16] = '{1'b0, 4'h4, 4'h0, 8'h00, 8'hAA, 4'hA, 16'h8830, 4'h0};
        tbl[17] = '{1'b0, 4'h0, 4'h0, 8'h0C, 8'hAA, 4'hE, 16'h8860, 4'h2};
        tbl[18] = '{1'b0, 4'h0, 4'h8, 8'h00, 8'hAA, 4'hE, 16'h6860, 4'h2};
        tbl[19] = '{1'b0, 4'h0, 4'h8, 8'h00, 8'h6A, 4'hE, 16'h5860, 4'h2};
        tbl[20] = '{1'b0, 4'h8, 4'h8, 8'h40, 8'hAA, 4'h6, 16'h8860, 4'h2};
        tbl[21] = '{1'b0, 4'h0, 4'h0, 8'h02, 8'hAA, 4'hE, 16'h8862, 4'h2};
        tbl[22] = '{1'b0, 4'h0, 4'h2, 8'h01, 8'hAA, 4'hF, 16'h8843, 4'h2};
        tbl[23] = '{1'b0, 4'h0, 4'hA, 8'h00, 8'hAA, 4'hF, 16'h6823, 4'h2};
        tbl[24] = '{1'b0, 4'h0, 4'h2, 8'h00, 8'hAA, 4'hF, 16'h6803, 4'h2};
        tbl[25] = '{1'b1, 4'h0, 4'hF, 8'h55, 8'hAA, 4'h0, 16'h8888, 4'h0};
        tbl[26] = '{1'b0, 4'h0, 4'h0, 8'h00, 8'hAA, 4'hF, 16'h8888, 4'h0};

        drive(1'b1, 4'h0, 4'h0, 8'h00, 8'hAA);
        repeat (2) begin
            pre_edge();
            post_edge();
        end
        chk("reset_credit_full", 32'(cr0), 32'h8888);
        chk("reset_flags_full", 32'({left0, low0, full0, err0}), 32'hF0F0);
        chk("reset_credit_empty", 32'(cr1), 32'h0000);
        chk("reset_flags_empty", 32'({left1, low1, full1, err1}), 32'h0F00);

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].rst, tbl[i].init, tbl[i].valid, tbl[i].give, tbl[i].amt);
            pre_edge();
            chk($sformatf("tbl%0d_rdy", i), 32'(rdy0), 32'(tbl[i].exp_rdy));
            post_edge();
            chk($sformatf("tbl%0d_credit", i), 32'(cr0), 32'(tbl[i].exp_cr));
            chk($sformatf("tbl%0d_flags", i), 32'({left0, low0, full0}),
                32'(exp_flags(tbl[i].exp_cr)));
            chk($sformatf("tbl%0d_err", i), 32'(err0), 32'(tbl[i].exp_err));
        end

        // Empty-start instance: fill channel 3, then reinit with a colliding give and take.
        repeat (2) begin
            drive(1'b0, 4'h0, 4'h0, 8'h80, 8'hAA);
            pre_edge();
            post_edge();
        end
        chk("empty_ch3_filled", 32'(cr1[15:12]), 32'd4);
        chk("full_ch3_overflow_err", 32'(err0[3]), 32'd1);
        drive(1'b0, 4'h8, 4'h8, 8'h40, 8'hAA);
        pre_edge();
        chk("init_ch3_rdy_empty", 32'(rdy1[3]), 32'd0);
        post_edge();
        chk("init_ch3_empty_count", 32'(cr1[15:12]), 32'd0);
        chk("init_ch3_full_count", 32'(cr0[15:12]), 32'd8);
        chk("init_ch3_err_clear", 32'(err0[3]), 32'd0);
        chk("init_others_untouched", 32'(cr0[11:0]), 32'h888);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] g, a;
            logic [3:0] v, in;
            for (int c = 0; c < 4; c++) begin
                v[c] = 1'($urandom_range(0, 1));
                g[c*2 +: 2] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                a[c*2 +: 2] = (v[c] && $urandom_range(0, 15) == 0) ? 2'd3
                                                                   : 2'($urandom_range(0, 2));
                in[c] = ($urandom_range(0, 19) == 0);
            end
            drive(($urandom_range(0, 59) == 0), in, v, g, a);
            pre_edge();
            post_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/credit_counter_multi.md
# credit_counter_multi

Multi-channel, multi-credit flow-control counter, generalising the single-credit counter. It keeps one independent credit pool per channel. Each pool accepts a return of up to MaxStep credits per cycle and a handshaked consumption of up to MaxStep credits per cycle. It sits at the sender side of credit-based links, such as multi-VC NoC ports and burst-capable DMA back-pressure.

## Interface
- NumChannels, 4: number of independent credit pools; ≥1.
- NumCredits, 8: capacity of each pool; ≥1.
- MaxStep, 2: maximum credits given or taken per channel per cycle; 1 ≤ MaxStep ≤ NumCredits.
- InitCreditEmpty, 0: pools start at 0 when set, else at NumCredits.
- LowWater, 1: low_o asserts when count < LowWater; 0 ≤ LowWater ≤ NumCredits.
- Derived (do not override): CntW = $clog2(NumCredits+1); StepW = $clog2(MaxStep+1); InitNumCredits = InitCreditEmpty ? 0 : NumCredits.

Ports. Bus fields are packed with channel c at [c*W +: W].
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- give_amt_i  in  NumChannels*StepW  credits returned this cycle per channel (0 = none).
- take_valid_i  in  NumChannels  consumption request per channel.
- take_amt_i  in  NumChannels*StepW  credits requested per channel; 0 is legal (no-op).
- take_ready_o  out  NumChannels  request granted this cycle.
- init_i  in  NumChannels  per-channel soft reinit; priority over give and take.
- credit_o  out  NumChannels*CntW  current count per channel.
- left_o  out  NumChannels  count != 0.
- low_o  out  NumChannels  count < LowWater.
- full_o  out  NumChannels  count == NumCredits.
- err_o  out  NumChannels  sticky protocol-error flag.

## Operation
- Per channel c: take_fire = take_valid_i[c] & take_ready_o[c].
- take_ready_o[c] = !rst_i & !init_i[c] & (credit_q[c] >= take_amt[c]).
  - Combinational from registered count and take_amt_i only.
  - Independent of take_valid_i and of the same-cycle give (no bypass).
- Next count, computed at CntW+1 bits: sum = credit_q + give_amt − (take_fire ? take_amt : 0).
  - Cannot underflow, because the grant is checked against credit_q.
  - sum > NumCredits: count saturates to NumCredits and err_o[c] sets.
- give_amt > MaxStep or take_amt > MaxStep: err_o[c] sets.
  - The give amount is still applied, with saturation.
  - The take is applied if granted.
- init_i[c]: count ← InitNumCredits and err_o[c] ← 0. Give and take are ignored that cycle; take_ready_o[c] = 0.
- Simultaneous give and take on one channel: net effect in one cycle (e.g. +1 −2 = −1).
- Channels are fully independent; there is no shared state.

## Timing
- Reset (rst_i high at a clock edge):
  - Every count ← InitNumCredits; err_o ← 0.
  - Hence full_o = !InitCreditEmpty, left_o = !InitCreditEmpty, low_o = (InitNumCredits < LowWater).
  - While rst_i is high, take_ready_o = 0 and gives are discarded.
  - A reset in mid-operation drops all in-flight gives and takes; normal operation resumes the cycle after rst_i falls.
- Count update latency is 1 cycle. credit_o, left_o, low_o, full_o and err_o are register-derived and reflect state after the last edge.
- take_ready_o has zero latency (combinational). A requester may hold take_valid_i and change take_amt_i while waiting; the grant always uses the current take_amt_i.
- err_o stays high until init_i[c] or rst_i clears it.

## Test plan
Default parameters (NumChannels=4, NumCredits=8, MaxStep=2, LowWater=1, InitCreditEmpty=0) unless stated.
- Reset then idle → credit_o = 8 on all channels; full_o = 4'hF, left_o = 4'hF, low_o = 0, err_o = 0; take_ready_o = 1 for take_amt = 2.
- Channel 0 holds take_valid with amt 2 for 5 cycles → count 8→6→4→2→0. The 5th take has ready = 0 and the count holds at 0; left_o[0] = 0, low_o[0] = 1.
- Channel 1 at 3, same cycle take 2 + give 1 → 2. Channel 1 at 1, take 2 + give 2 → ready = 0 (no bypass); next cycle 3.
- Channel 2 at 8, give 1 → stays 8, err_o[2] = 1. Hold 3 cycles → err_o stays 1. Then init_i[2] → err_o[2] = 0, count 8. Separately, give_amt = 3 → err_o set.
- Channel 3 at 5, init_i with take 2 and give 1 same cycle → take_ready_o[3] = 0; next count 8. Rerun with InitCreditEmpty=1 → 0. Other channels are unaffected.
- rst_i asserted mid-traffic (counts 3/0/8/6, takes pending) → take_ready_o = 0 during reset; next cycle all counts 8, err_o = 0.
